// File: rtl/key_event_ctrl.sv
// key_event_ctrl: classifies debounced key presses as single/double/long (with auto-repeat)
// and maintains the display mode index and edge threshold.
module key_event_ctrl #(
  parameter int         LONG_CNT = 50000000,
  parameter int         DBL_CNT  = 15000000,
  parameter int         REP_CNT  = 10000000,
  parameter int         REL_CNT  = 500000,
  parameter int         TMR_W    = 26,
  parameter int         MODE_NUM = 3,
  parameter logic [7:0] THR_INIT = 8'd64,
  parameter logic [7:0] THR_STEP = 8'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_sw,
  input  logic       key_down_int,
  output logic [1:0] mode,
  output logic [7:0] thresh,
  output logic       evt_single,
  output logic       evt_double,
  output logic       evt_long
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;
  state_t           state_q;
  logic [1:0]       sync_q;
  logic [TMR_W-1:0] tmr_q, rel_cnt_q;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       thr_q, thr_d;
  logic [8:0]       thr_sum;
  logic             key_lvl, rel_ok, evt_single_q, evt_double_q, evt_long_q;
  assign mode       = mode_q;
  assign thresh     = thr_q;
  assign evt_single = evt_single_q;
  assign evt_double = evt_double_q;
  assign evt_long   = evt_long_q;
  always_comb begin
    key_lvl = sync_q[1];
    rel_ok  = rel_cnt_q == TMR_W'(REL_CNT - 1);
    thr_sum = {1'b0, thr_q} + {1'b0, THR_STEP};
    thr_d   = thr_sum[8] ? 8'hff : thr_sum[7:0];
    mode_d  = (mode_q == 2'(MODE_NUM - 1)) ? 2'd0 : mode_q + 2'd1;
  end
  // release is only accepted after REL_CNT consecutive released-level cycles
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync_q    <= 2'b11;
      rel_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[0], key_sw};
      rel_cnt_q <= !key_lvl ? '0 : rel_ok ? rel_cnt_q : rel_cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      mode_q       <= '0;
      thr_q        <= THR_INIT;
      evt_single_q <= 1'b0;
      evt_double_q <= 1'b0;
      evt_long_q   <= 1'b0;
    end else begin
      evt_single_q <= 1'b0;
      evt_double_q <= 1'b0;
      evt_long_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          tmr_q <= '0;
          if (key_down_int) state_q <= PRESS1;
        end
        PRESS1: begin
          if (rel_ok) begin
            state_q <= WAIT2;
            tmr_q   <= '0;
          end else if (tmr_q == TMR_W'(LONG_CNT - 1)) begin
            state_q    <= LONG;
            tmr_q      <= '0;
            evt_long_q <= 1'b1;
            thr_q      <= thr_d;
          end else tmr_q <= tmr_q + 1'b1;
        end
        WAIT2: begin
          if (key_down_int) begin
            state_q      <= PRESS2;
            tmr_q        <= '0;
            evt_double_q <= 1'b1;
            thr_q        <= THR_INIT;
          end else if (tmr_q == TMR_W'(DBL_CNT - 1)) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            evt_single_q <= 1'b1;
            mode_q       <= mode_d;
          end else tmr_q <= tmr_q + 1'b1;
        end
        PRESS2: begin
          tmr_q <= '0;
          if (rel_ok) state_q <= IDLE;
        end
        LONG: begin
          if (rel_ok) begin
            state_q <= IDLE;
            tmr_q   <= '0;
          end else if (tmr_q == TMR_W'(REP_CNT - 1)) begin
            tmr_q      <= '0;
            evt_long_q <= 1'b1;
            thr_q      <= thr_d;
          end else tmr_q <= tmr_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          tmr_q   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed key sequences; expected events queued at stimulus time,
// checked by an independent monitor whenever the DUT pulses an event.
module tb_key_event_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, key_sw = 1'b1, key_down_int = 1'b0;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic evt_single, evt_double, evt_long;
  int checks = 0, errors = 0;
  typedef struct packed {logic [2:0] kind; logic [1:0] mode; logic [7:0] thr;} exp_t;
  exp_t q[$];
  logic [1:0] exp_mode = 2'd0;
  logic [7:0] exp_thr = 8'd64;

  key_event_ctrl #(.LONG_CNT(100), .DBL_CNT(50), .REP_CNT(20), .REL_CNT(4), .TMR_W(26),
    .MODE_NUM(3), .THR_INIT(8'd64), .THR_STEP(8'd16)) dut (
    .clk(clk), .rst_n(rst_n), .key_sw(key_sw), .key_down_int(key_down_int), .mode(mode),
    .thresh(thresh), .evt_single(evt_single), .evt_double(evt_double), .evt_long(evt_long));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (evt_single | evt_double | evt_long) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_evt got evt=%b mode=%0d thr=%0d", {evt_long, evt_double, evt_single}, mode, thresh);
      end else begin
        e = q.pop_front();
        if ({evt_long, evt_double, evt_single, mode, thresh} != e) begin
          errors++;
          $display("FAIL evt got evt=%b mode=%0d thr=%0d want evt=%b mode=%0d thr=%0d",
            {evt_long, evt_double, evt_single}, mode, thresh, e.kind, e.mode, e.thr);
        end
      end
    end
  end

  function automatic logic [7:0] step(input logic [7:0] t);
    int s = int'(t) + 16;
    return s > 255 ? 8'd255 : 8'(s);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic exp_single();
    exp_mode = 2'((int'(exp_mode) + 1) % 3);
    q.push_back({3'b001, exp_mode, exp_thr});
  endtask

  task automatic exp_double();
    exp_thr = 8'd64;
    q.push_back({3'b010, exp_mode, exp_thr});
  endtask

  task automatic exp_long(input int n);
    for (int i = 0; i < n; i++) begin
      exp_thr = step(exp_thr);
      q.push_back({3'b100, exp_mode, exp_thr});
    end
  endtask

  // key goes low, then the debounced pulse; returns one cycle after the pulse edge
  task automatic press();
    key_sw = 1'b0;
    tick(4);
    key_down_int = 1'b1;
    tick(1);
    key_down_int = 1'b0;
  endtask

  task automatic single_click();
    exp_single();
    press();
    tick(29);
    key_sw = 1'b1;
    tick(70);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_mode"}, mode, 0);
    chk({name, "_thr"}, thresh, 64);
    chk({name, "_evt"}, {evt_long, evt_double, evt_single}, 0);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b0;
    chk_idle_outputs("reset");
    tick(5);
    chk_idle_outputs("idle");
    single_click();
    single_click();
    single_click();
    chk("wrap_mode", mode, 0);
    exp_double();
    press();
    tick(29);
    key_sw = 1'b1;
    tick(25);
    press();
    tick(10);
    key_sw = 1'b1;
    tick(60);
    exp_long(15);
    press();
    tick(389);
    key_sw = 1'b1;
    tick(20);
    chk("sat_thr", thresh, 255);
    // release lands exactly on the long-press expiry: must enter WAIT2 and end as a single
    exp_single();
    press();
    tick(94);
    key_sw = 1'b1;
    tick(80);
    // second pulse lands exactly on the double-click window expiry: double wins
    exp_double();
    press();
    tick(29);
    key_sw = 1'b1;
    tick(50);
    key_sw = 1'b0;
    tick(5);
    key_down_int = 1'b1;
    tick(1);
    key_down_int = 1'b0;
    tick(10);
    key_sw = 1'b1;
    tick(70);
    single_click();
    exp_long(3);
    press();
    tick(149);
    chk("pre_rst_mode", mode, 2);
    chk("pre_rst_thr", thresh, 112);
    rst_n = 1'b1;
    tick(1);
    rst_n = 1'b0;
    exp_mode = 2'd0;
    exp_thr = 8'd64;
    chk_idle_outputs("mid_rst");
    key_sw = 1'b1;
    tick(10);
    single_click();
    tick(5);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Sits directly downstream of the key debounce stage.
- Consumes the one-cycle debounced press pulse and the raw key level, and classifies each press as single click, double click or long press (with auto-repeat).
- Maintains the display mode index and the edge-detection threshold that drive the Sobel/edge pipeline.

Parameters:
- LONG_CNT, 50000000, hold cycles (from press pulse) before a long press is declared (1 s at 50 MHz).
- DBL_CNT, 15000000, cycles after release within which a second press counts as a double click.
- REP_CNT, 10000000, auto-repeat interval while held in long press.
- REL_CNT, 500000, consecutive released-level cycles required to accept a release (10 ms).
- TMR_W, 26, timer width; must hold max(LONG_CNT, DBL_CNT, REP_CNT).
- MODE_NUM, 3, number of display modes (2..4).
- THR_INIT, 8'd64, threshold reset/double-click value.
- THR_STEP, 8'd16, threshold increment per long/repeat event.

Ports:
- clk, input, 1, system clock (50 MHz).
- rst_n, input, 1, reset: synchronous and active-high; asserted when 1 and sampled only on the clk rising edge.
- key_sw, input, 1, raw key level (1 = released, 0 = pressed), asynchronous.
- key_down_int, input, 1, one-cycle debounced press pulse from the debounce stage.
- mode, output, 2, current display mode, 0..MODE_NUM-1.
- thresh, output, 8, edge threshold.
- evt_single, output, 1, one-cycle pulse on single click.
- evt_double, output, 1, one-cycle pulse on double click.
- evt_long, output, 1, one-cycle pulse on long press and on each repeat.

Behaviour:
- Reset values:
  - state = IDLE; mode = 0; thresh = THR_INIT; all evt_* = 0; timers = 0.
  - key_sw synchronizer flops = 1.
- Input sync: key_sw goes through a 2-flop synchronizer to give key_lvl.
- Release detection:
  - rel_cnt counts consecutive cycles with key_lvl = 1 and clears on key_lvl = 0.
  - rel_ok is asserted when rel_cnt reaches REL_CNT-1; rel_cnt saturates there.
- The single timer clears on every state change.
- States and transitions:
  - IDLE: key_down_int -> PRESS1.
  - PRESS1: timer counts while not rel_ok.
    - rel_ok -> WAIT2.
    - timer == LONG_CNT-1 and not rel_ok -> LONG; evt_long; thresh step.
  - WAIT2: timer counts.
    - key_down_int -> PRESS2; evt_double; thresh = THR_INIT.
    - Otherwise timer == DBL_CNT-1 -> IDLE; evt_single; mode advance.
  - PRESS2: rel_ok -> IDLE. No long detection in this state.
  - LONG: rel_ok -> IDLE.
    - Otherwise timer == REP_CNT-1 -> stay in LONG; timer = 0; evt_long; thresh step.
- Arithmetic:
  - Mode advance: mode = (mode == MODE_NUM-1) ? 0 : mode+1.
  - Thresh step: thresh = (thresh > 255-THR_STEP) ? 255 : thresh+THR_STEP, i.e. saturating with a 9-bit intermediate sum and no wrap.
- Latency:
  - The condition is evaluated on registered state/inputs.
  - The state change, the register update and the evt_* assertion all occur on the same next rising edge.
  - evt_* is high for exactly one cycle.
  - At most one evt_* is high in any cycle.
- Simultaneous and boundary events:
  - key_down_int in PRESS1, PRESS2 or LONG is ignored.
  - key_down_int on the same cycle as DBL_CNT expiry in WAIT2: double wins, no single.
  - rel_ok on the same cycle as LONG_CNT expiry in PRESS1: release wins (-> WAIT2, no long).
  - rel_ok on the same cycle as REP_CNT expiry in LONG: release wins, no step.
  - thresh already at 255: further steps hold 255, but evt_long still pulses.
  - Reset mid-operation: all registers return to their reset values on that edge regardless of state; pending events are discarded.

Test Plan:
Bench parameters: LONG_CNT=100, DBL_CNT=50, REP_CNT=20, REL_CNT=4, MODE_NUM=3, THR_INIT=64, THR_STEP=16.
- Single click: pulse key_down_int, hold key_sw=0 for 30 cycles, then release -> evt_single once, ~50 cycles after rel_ok; mode 0->1; thresh stays 64.
- Mode wrap: three single clicks -> mode 1, 2, then 0; three evt_single pulses, no other events.
- Double click: press, release, second key_down_int 20 cycles after rel_ok -> evt_double once; no evt_single; thresh=64; mode unchanged.
- Long press with repeat and saturation: hold 400 cycles -> evt_long at 100 cycles, then every 20 cycles; thresh 80, 96, ... saturates at 255 and holds; release -> IDLE.
- Tie cases: key_down_int exactly at DBL_CNT expiry -> evt_double only. rel_ok exactly at LONG_CNT expiry -> no evt_long; WAIT2 entered.
- Mid-operation reset: assert rst_n=1 for one cycle during LONG with thresh=112, mode=2 -> next cycle mode=0, thresh=64, evt_*=0, state IDLE; subsequent key_down_int is handled normally.
